im_port_arbiter: RTL

Sequences and shares the single-port instruction Block RAM between the CPU fetch stage and the program loader. Holds the core in a BOOT phase while the loader writes the image, then arbitrates fetch and loader traffic round-robin. Translates byte addresses based at 0x3000 into RAM word addresses and steers the 1-cycle RAM read data back to the requester that issued it.

---
 rtl/im_port_arbiter_pkg.sv | 17 +
 rtl/im_port_arbiter_if.sv | 45 ++++
 rtl/im_addr_xlate.sv | 28 ++
 rtl/im_port_arbiter.sv | 118 +++++++++++
 4 files changed

// File: rtl/im_port_arbiter_pkg.sv
// Shared types and defaults for the instruction-memory port arbiter.
package im_port_arbiter_pkg;

  localparam logic [31:0] BASE_ADDR_DEF = 32'h0000_3000;
  localparam int unsigned ADDR_W_DEF    = 13;

  typedef enum logic {
    BOOT,
    RUN
  } state_e;

  typedef enum logic {
    FETCH,
    LOADER
  } req_tag_e;

endpackage

// File: rtl/im_port_arbiter_if.sv
// Fetch, loader and RAM signals of the instruction-memory arbiter; slave = arbiter side.
interface im_port_arbiter_if
  import im_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) ();

  logic              f_req;
  logic [31:0]       f_pc;
  logic              f_gnt;
  logic              f_rvalid;
  logic [31:0]       f_rdata;
  logic              f_err;

  logic              l_req;
  logic              l_we;
  logic [31:0]       l_addr;
  logic [31:0]       l_wdata;
  logic              l_done;
  logic              l_gnt;
  logic              l_rvalid;
  logic [31:0]       l_rdata;
  logic              l_err;

  logic              booting;
  logic [ADDR_W:0]   words_loaded;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_din;
  logic [31:0]       ram_dout;

  modport master (
    output f_req, f_pc, l_req, l_we, l_addr, l_wdata, l_done, ram_dout,
    input  f_gnt, f_rvalid, f_rdata, f_err, l_gnt, l_rvalid, l_rdata, l_err,
    input  booting, words_loaded, ram_we, ram_addr, ram_din
  );

  modport slave (
    input  f_req, f_pc, l_req, l_we, l_addr, l_wdata, l_done, ram_dout,
    output f_gnt, f_rvalid, f_rdata, f_err, l_gnt, l_rvalid, l_rdata, l_err,
    output booting, words_loaded, ram_we, ram_addr, ram_din
  );

endinterface

// File: rtl/im_addr_xlate.sv
// Byte address to RAM word address. IM_RANGE_CHECK_EN adds alignment/range fault
// detection; without it the fault flag is 0 and the address wraps modulo depth.
module im_addr_xlate
  import im_port_arbiter_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEF,
  parameter int unsigned ADDR_W    = ADDR_W_DEF
) (
  input  logic [31:0]       addr,
  output logic [ADDR_W-1:0] waddr,
  output logic              fault
);

  logic [31:0] off;

  assign off   = addr - BASE_ADDR;
  assign waddr = off[ADDR_W+1:2];

`ifdef IM_RANGE_CHECK_EN
  // Upper offset bits nonzero means off >= 4 * depth.
  assign fault = (off[1:0] != 2'b00) || (addr < BASE_ADDR) || (off[31:ADDR_W+2] != '0);
`else
  logic xlate_unused;
  assign xlate_unused = ^{off[31:ADDR_W+2], off[1:0]};
  assign fault        = 1'b0;
`endif

endmodule

// File: rtl/im_port_arbiter.sv
// Shares the single-port instruction BRAM between fetch and loader: BOOT phase for
// loading, then round-robin arbitration. Address checking via IM_RANGE_CHECK_EN.
module im_port_arbiter
  import im_port_arbiter_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEF,
  parameter int unsigned ADDR_W    = ADDR_W_DEF
) (
  input logic              clk,
  input logic              reset,
  im_port_arbiter_if.slave bus
);

  state_e            state_q, state_d;
  req_tag_e          last_q, last_d;
  logic              rd_pend_q;
  req_tag_e          rd_tag_q;
  logic              rd_err_q;
  logic [ADDR_W:0]   words_q;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr;

  logic              f_gnt, l_gnt;
  logic              f_fault, l_fault;
  logic [ADDR_W-1:0] f_waddr, l_waddr;
  logic              wr_ok, rv, f_rv, l_rv;

  im_addr_xlate #(.BASE_ADDR(BASE_ADDR), .ADDR_W(ADDR_W)) u_f_xlate (
    .addr  (bus.f_pc),
    .waddr (f_waddr),
    .fault (f_fault)
  );

  im_addr_xlate #(.BASE_ADDR(BASE_ADDR), .ADDR_W(ADDR_W)) u_l_xlate (
    .addr  (bus.l_addr),
    .waddr (l_waddr),
    .fault (l_fault)
  );

  // Grants are forced low while reset is asserted so outputs show reset values at once.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    f_gnt   = 1'b0;
    l_gnt   = 1'b0;
    if (!reset) begin
      unique case (state_q)
        BOOT: begin
          l_gnt = bus.l_req;
          if (bus.l_done) state_d = RUN;
        end
        RUN: begin
          if (bus.f_req && bus.l_req) begin
            if (last_q == FETCH) begin
              l_gnt  = 1'b1;
              last_d = LOADER;
            end else begin
              f_gnt  = 1'b1;
              last_d = FETCH;
            end
          end else begin
            f_gnt = bus.f_req;
            l_gnt = bus.l_req;
          end
        end
        default: state_d = BOOT;
      endcase
    end
  end

  always_comb begin
    ram_addr = ram_addr_q;
    if (f_gnt && !f_fault)      ram_addr = f_waddr;
    else if (l_gnt && !l_fault) ram_addr = l_waddr;
  end

  assign wr_ok = l_gnt && bus.l_we && !l_fault;

  // A read issued just before reset must not surface while reset is held.
  assign rv   = rd_pend_q && !reset;
  assign f_rv = rv && (rd_tag_q == FETCH);
  assign l_rv = rv && (rd_tag_q == LOADER);

  assign bus.f_gnt        = f_gnt;
  assign bus.l_gnt        = l_gnt;
  assign bus.f_rvalid     = f_rv;
  assign bus.l_rvalid     = l_rv;
  assign bus.f_rdata      = (f_rv && !rd_err_q) ? bus.ram_dout : '0;
  assign bus.l_rdata      = (l_rv && !rd_err_q) ? bus.ram_dout : '0;
  assign bus.f_err        = f_rv && rd_err_q;
  assign bus.l_err        = (l_gnt && bus.l_we && l_fault) || (l_rv && rd_err_q);
  assign bus.booting      = reset || (state_q == BOOT);
  assign bus.words_loaded = words_q;
  assign bus.ram_we       = wr_ok;
  assign bus.ram_addr     = ram_addr;
  assign bus.ram_din      = bus.l_wdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= BOOT;
      last_q     <= FETCH;
      rd_pend_q  <= 1'b0;
      rd_tag_q   <= FETCH;
      rd_err_q   <= 1'b0;
      words_q    <= '0;
      ram_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      rd_pend_q  <= f_gnt || (l_gnt && !bus.l_we);
      rd_tag_q   <= f_gnt ? FETCH : LOADER;
      rd_err_q   <= f_gnt ? f_fault : l_fault;
      ram_addr_q <= ram_addr;
      // Top bit set only at exactly 2^ADDR_W, which is the saturation point.
      if (wr_ok && !words_q[ADDR_W]) words_q <= words_q + 1'b1;
    end
  end

endmodule
